// File: rtl/ysyx_25060170_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Includes the register-address width, the FSM state encoding and the control bundle type.
package ysyx_25060170_hazard_ctrl_pkg;

    localparam int REGADDR_W = 5;

    localparam logic [1:0] ysyx_25060170_HZ_S_RUN     = 2'd0;
    localparam logic [1:0] ysyx_25060170_HZ_S_EXBUSY  = 2'd1;
    localparam logic [1:0] ysyx_25060170_HZ_S_MEMWAIT = 2'd2;
    localparam logic [1:0] ysyx_25060170_HZ_S_DRAIN   = 2'd3;

    typedef struct packed {
        logic pc_hold;
        logic ifid_hold;
        logic idex_hold;
        logic exls_hold;
        logic id_flush;
        logic ie_flush;
        logic ls_flush;
    } hz_ctrl_t;

endpackage

// File: rtl/ysyx_25060170_sat_cnt.sv
// Saturating up-counter: adds one per cycle while inc is high.
// Once it reaches all-ones it stays there until reset.
module ysyx_25060170_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ysyx_25060170_hazard_ctrl.sv
// Central hold/flush control for the 5-stage pipeline.
// Covers load-use, EX busy, LS wait, redirect, trap drain, and the stall/flush counters.
module ysyx_25060170_hazard_ctrl
    import ysyx_25060170_hazard_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REGADDR_W-1:0] id_rs1_addr,
    input  logic [REGADDR_W-1:0] id_rs2_addr,
    input  logic                 id_rs1_ren,
    input  logic                 id_rs2_ren,
    input  logic [REGADDR_W-1:0] ex_rd_addr,
    input  logic                 ex_rd_ena,
    input  logic                 ex_load_flag,
    input  logic                 ex_busy,
    input  logic                 ex_redirect,
    input  logic                 ls_mem_wait,
    input  logic                 ls_trap,
    output logic                 pc_hold,
    output logic                 ifid_hold,
    output logic                 idex_hold,
    output logic                 exls_hold,
    output logic                 id_flush,
    output logic                 ie_flush,
    output logic                 ls_flush,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

    logic [1:0] state, state_nxt;
    logic [2:0] drain_cnt, drain_nxt;
    hz_ctrl_t   ctrl;
    logic       load_use;

    assign load_use = ex_load_flag & ex_rd_ena & (ex_rd_addr != '0) &
                      ((id_rs1_ren & (id_rs1_addr == ex_rd_addr)) |
                       (id_rs2_ren & (id_rs2_addr == ex_rd_addr)));

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        ctrl      = '0;
        state_nxt = ysyx_25060170_HZ_S_RUN;
        drain_nxt = drain_cnt;
        if (state == ysyx_25060170_HZ_S_DRAIN) begin
            ctrl.ls_flush = 1'b1;
            state_nxt     = ysyx_25060170_HZ_S_DRAIN;
            if (ls_trap) begin
                drain_nxt = DRAIN_LOAD;
            end else if (drain_cnt == 3'd0) begin
                state_nxt = ysyx_25060170_HZ_S_RUN;
            end else begin
                drain_nxt = drain_cnt - 3'd1;
            end
        end else if (ls_trap) begin
            ctrl.ls_flush = 1'b1;
            state_nxt     = ysyx_25060170_HZ_S_DRAIN;
            drain_nxt     = DRAIN_LOAD;
        end else if (ls_mem_wait) begin
            ctrl.pc_hold   = 1'b1;
            ctrl.ifid_hold = 1'b1;
            ctrl.idex_hold = 1'b1;
            ctrl.exls_hold = 1'b1;
            state_nxt      = (state == ysyx_25060170_HZ_S_EXBUSY) ? ysyx_25060170_HZ_S_EXBUSY
                                                                  : ysyx_25060170_HZ_S_MEMWAIT;
        end else if (ex_busy) begin
            // A busy EX swallows any redirect or load-use: the front end is frozen anyway.
            ctrl.pc_hold   = 1'b1;
            ctrl.ifid_hold = 1'b1;
            ctrl.idex_hold = 1'b1;
            state_nxt      = ysyx_25060170_HZ_S_EXBUSY;
        end else if (ex_redirect) begin
            ctrl.ie_flush = 1'b1;
        end else if (load_use) begin
            ctrl.pc_hold   = 1'b1;
            ctrl.ifid_hold = 1'b1;
            ctrl.id_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ysyx_25060170_HZ_S_RUN;
            drain_cnt <= 3'd0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    // Outputs are forced quiet while reset is asserted, independent of the inputs.
    assign pc_hold   = rst_n & ctrl.pc_hold;
    assign ifid_hold = rst_n & ctrl.ifid_hold;
    assign idex_hold = rst_n & ctrl.idex_hold;
    assign exls_hold = rst_n & ctrl.exls_hold;
    assign id_flush  = rst_n & ctrl.id_flush;
    assign ie_flush  = rst_n & ctrl.ie_flush;
    assign ls_flush  = rst_n & ctrl.ls_flush;

    ysyx_25060170_sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pc_hold),
        .cnt   (stall_cnt)
    );

    ysyx_25060170_sat_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (id_flush | ie_flush | ls_flush),
        .cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_ysyx_25060170_hazard_ctrl.sv
// Directed bench for the hazard controller: a default-width instance plus a CNT_W=4
// instance sharing the same stimulus so that saturation can be observed.
module tb_ysyx_25060170_hazard_ctrl;

    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b1100100;
    localparam logic [6:0] C_RDIR = 7'b0000010;
    localparam logic [6:0] C_BUSY = 7'b1110000;
    localparam logic [6:0] C_MEMW = 7'b1111000;
    localparam logic [6:0] C_TRAP = 7'b0000001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic       id_rs1_ren, id_rs2_ren, ex_rd_ena, ex_load_flag;
    logic       ex_busy, ex_redirect, ls_mem_wait, ls_trap;

    logic        pc_hold, ifid_hold, idex_hold, exls_hold, id_flush, ie_flush, ls_flush;
    logic [31:0] stall_cnt, flush_cnt;
    logic        s_pc_hold, s_ifid_hold, s_idex_hold, s_exls_hold, s_id_flush, s_ie_flush, s_ls_flush;
    logic [3:0]  s_stall_cnt, s_flush_cnt;
    logic [6:0]  ctl, s_ctl;

    int n_vec = 0;
    int n_err = 0;
    int es = 0, ef = 0, es4 = 0, ef4 = 0;

    always #5 clk = ~clk;

    assign ctl   = {pc_hold, ifid_hold, idex_hold, exls_hold, id_flush, ie_flush, ls_flush};
    assign s_ctl = {s_pc_hold, s_ifid_hold, s_idex_hold, s_exls_hold, s_id_flush, s_ie_flush, s_ls_flush};

    ysyx_25060170_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_ren(id_rs1_ren), .id_rs2_ren(id_rs2_ren),
        .ex_rd_addr(ex_rd_addr), .ex_rd_ena(ex_rd_ena), .ex_load_flag(ex_load_flag),
        .ex_busy(ex_busy), .ex_redirect(ex_redirect),
        .ls_mem_wait(ls_mem_wait), .ls_trap(ls_trap),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_hold(idex_hold), .exls_hold(exls_hold),
        .id_flush(id_flush), .ie_flush(ie_flush), .ls_flush(ls_flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    ysyx_25060170_hazard_ctrl #(.DRAIN_CYCLES(2), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_ren(id_rs1_ren), .id_rs2_ren(id_rs2_ren),
        .ex_rd_addr(ex_rd_addr), .ex_rd_ena(ex_rd_ena), .ex_load_flag(ex_load_flag),
        .ex_busy(ex_busy), .ex_redirect(ex_redirect),
        .ls_mem_wait(ls_mem_wait), .ls_trap(ls_trap),
        .pc_hold(s_pc_hold), .ifid_hold(s_ifid_hold), .idex_hold(s_idex_hold), .exls_hold(s_exls_hold),
        .id_flush(s_id_flush), .ie_flush(s_ie_flush), .ls_flush(s_ls_flush),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs1_addr = '0; id_rs2_addr = '0; ex_rd_addr = '0;
        id_rs1_ren = 0; id_rs2_ren = 0; ex_rd_ena = 0; ex_load_flag = 0;
        ex_busy = 0; ex_redirect = 0; ls_mem_wait = 0; ls_trap = 0;
    endtask

    // Called at a falling edge with inputs already applied: checks this cycle's
    // controls and the counters accumulated so far, then advances one clock.
    task automatic cyc(input string tag, input logic [6:0] exp);
        #1;
        check({tag, ".ctl"}, {25'd0, ctl}, {25'd0, exp});
        check({tag, ".sat_ctl"}, {25'd0, s_ctl}, {25'd0, exp});
        check({tag, ".stall"}, stall_cnt, es);
        check({tag, ".flush"}, flush_cnt, ef);
        check({tag, ".sat_stall"}, {28'd0, s_stall_cnt}, es4);
        check({tag, ".sat_flush"}, {28'd0, s_flush_cnt}, ef4);
        if (exp[6]) begin
            es++;
            if (es4 < 15) es4++;
        end
        if (|exp[2:0]) begin
            ef++;
            if (ef4 < 15) ef4++;
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        ls_trap = 1; ls_mem_wait = 1; ex_busy = 1;
        #2;
        check("rst.ctl", {25'd0, ctl}, 32'd0);
        check("rst.stall", stall_cnt, 32'd0);
        check("rst.flush", flush_cnt, 32'd0);
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;

        cyc("idle", C_NONE);

        ex_load_flag = 1; ex_rd_ena = 1; ex_rd_addr = 5'd5; id_rs2_addr = 5'd5; id_rs2_ren = 1;
        cyc("lu_rs2", C_LU);
        ex_load_flag = 0;
        cyc("lu_gone", C_NONE);
        ex_load_flag = 1; ex_rd_addr = 5'd0; id_rs2_addr = 5'd0;
        cyc("lu_x0", C_NONE);
        ex_rd_addr = 5'd7; id_rs1_addr = 5'd7; id_rs1_ren = 1; id_rs2_ren = 0;
        cyc("lu_rs1", C_LU);
        id_rs1_ren = 0;
        cyc("lu_noren", C_NONE);
        clear_inputs();

        ex_redirect = 1;
        cyc("redir", C_RDIR);
        ex_redirect = 0;

        ex_busy = 1;
        cyc("busy1", C_BUSY);
        ex_redirect = 1;
        cyc("busy2_redir", C_BUSY);
        ex_redirect = 0;
        cyc("busy3", C_BUSY);
        cyc("busy4", C_BUSY);
        ex_busy = 0;
        cyc("busy_exit", C_NONE);

        ex_busy = 1;
        cyc("bw_busy", C_BUSY);
        ls_mem_wait = 1;
        for (int i = 0; i < 3; i++) cyc("bw_memw", C_MEMW);
        ls_mem_wait = 0; ex_busy = 0;
        cyc("bw_exit", C_NONE);

        ls_trap = 1;
        cyc("trap", C_TRAP);
        ls_trap = 0; ex_busy = 1;
        cyc("drain1_busy_ign", C_TRAP);
        ex_busy = 0;
        cyc("drain2", C_TRAP);
        cyc("trap_done", C_NONE);

        ls_trap = 1;
        cyc("trap2", C_TRAP);
        cyc("trap2_reload", C_TRAP);
        ls_trap = 0;
        cyc("trap2_d1", C_TRAP);
        cyc("trap2_d2", C_TRAP);
        cyc("trap2_done", C_NONE);

        ls_mem_wait = 1;
        cyc("mw", C_MEMW);
        ls_trap = 1;
        cyc("mw_trap", C_TRAP);
        ls_trap = 0; ls_mem_wait = 0;
        cyc("mw_d1", C_TRAP);
        cyc("mw_d2", C_TRAP);
        cyc("mw_done", C_NONE);

        ls_mem_wait = 1;
        for (int i = 0; i < 20; i++) cyc("sat_hold", C_MEMW);
        ls_mem_wait = 0;
        #1;
        check("sat_stall_15", {28'd0, s_stall_cnt}, 32'd15);
        @(negedge clk);
        check("sat_stall_stays", {28'd0, s_stall_cnt}, 32'd15);

        ls_trap = 1;
        cyc("rr_trap", C_TRAP);
        ls_trap = 0; ls_mem_wait = 1;
        #1;
        rst_n = 1'b0;
        #1;
        check("rr.ctl", {25'd0, ctl}, 32'd0);
        check("rr.stall", stall_cnt, 32'd0);
        check("rr.flush", flush_cnt, 32'd0);
        check("rr.sat_stall", {28'd0, s_stall_cnt}, 32'd0);
        @(negedge clk);
        ls_mem_wait = 0;
        rst_n = 1'b1;
        es = 0; ef = 0; es4 = 0; ef4 = 0;
        cyc("rr_run", C_NONE);
        cyc("rr_run2", C_NONE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
